player_motion_controller: RTL and testbench
===========================================

PLAYER_MOTION_CONTROLLER -- requirements
Module: player_motion_controller

Interface
REQ-001 Parameter TILEMAP_LENGTH, 2000, tilemap width in tiles; legal x is 0..TILEMAP_LENGTH-1.
REQ-002 Parameter START_X, 1, x_location value after reset.
REQ-003 Parameter START_Y, 1, y_location value after reset; y=0 is the bottom row, y=15 is the top row.
REQ-004 Parameter JUMP_HEIGHT, 3, maximum number of tiles ascended per jump.
REQ-005 clock  in  1  single clock; all logic is on posedge clock.
REQ-006 resetn  in  1  reset, synchronous and active-low.
REQ-007 frame_tick  in  1  one-cycle pulse that requests one motion update.
REQ-008 btn_left, btn_right, btn_jump  in  1 each  player controls, level-sensitive.
REQ-009 dbc_done  in  1  collision detector idle/done level.
REQ-010 coll_left, coll_right, coll_up, coll_down  in  1 each  blocked flags from the collision detector for the neighbour tile in that direction.
REQ-011 dbc_enable  out  1  one-cycle start pulse to the collision detector.
REQ-012 x_location  out  11  player tile column; also drives the collision detector.
REQ-013 y_location  out  4  player tile row; also drives the collision detector.
REQ-014 update_done  out  1  one-cycle pulse when the new position is committed.
REQ-015 overrun  out  1  one-cycle pulse when a frame_tick is dropped.

Function
REQ-016 FSM states: IDLE, REQUEST, WAIT_BUSY, WAIT_DONE, MOVE_X, MOVE_Y, COMMIT.
REQ-017 IDLE: on frame_tick, latch btn_left, btn_right and btn_jump into internal registers, then go to REQUEST; otherwise stay in IDLE.
REQ-018 REQUEST: dbc_enable=1 for exactly this cycle; next state is WAIT_BUSY.
REQ-019 WAIT_BUSY: advance to WAIT_DONE once dbc_done=0.
REQ-020 WAIT_DONE: advance to MOVE_X once dbc_done=1; the coll_* flags are sampled in this transition cycle.
REQ-021 The detector needs at least 9 cycles per run; there is no timeout, and the FSM waits indefinitely.
REQ-022 MOVE_X: if exactly one of left/right is latched and the matching coll_* flag is 0, x moves by ±1.
REQ-023 MOVE_X: when left and right are both latched, x is unchanged.
REQ-024 x saturates at 0 and at TILEMAP_LENGTH-1; x never wraps.
REQ-025 MOVE_Y: an internal counter jump_left (2 bits) is kept.
REQ-026 Grounded means coll_down=1 or y=0.
REQ-027 If grounded, btn_jump is latched and jump_left=0, set jump_left=JUMP_HEIGHT.
REQ-028 If jump_left>0: when coll_up=0 and y<15, y+1 and jump_left-1; otherwise jump_left=0 (head bump) and y is unchanged this update.
REQ-029 If jump_left=0 and not grounded, y-1 (gravity, one tile per update).
REQ-030 The x and y moves use flags from the same detector run; x is applied before y with no re-check.
REQ-031 COMMIT: update_done=1 for one cycle, then return to IDLE.
REQ-032 x_location and y_location change only in MOVE_X and MOVE_Y and are otherwise stable; they are held constant while the detector runs.
REQ-033 A frame_tick in any state other than IDLE is dropped and pulses overrun in the same cycle.
REQ-034 Latency from frame_tick to update_done = detector run + 6 cycles.

Reset
REQ-035 While resetn=0 at a posedge: FSM=IDLE, x=START_X, y=START_Y, jump_left=0, latched buttons=0, dbc_enable=0, update_done=0, overrun=0.
REQ-036 Reset mid-update abandons the update with no partial position commit.
REQ-037 After reset, the FSM ignores a detector run still in progress; the next REQUEST waits for dbc_done via WAIT_BUSY/WAIT_DONE.

Structure
REQ-038 A shared package holds the FSM state encoding, TILEMAP_LENGTH, and the X_W=11 and Y_W=4 widths, reused by the collision detector and the tile renderer.
REQ-039 One natural sub-module, jump_counter, holds jump_left with load, decrement and clear controls.
REQ-040 The remainder is a single FSM plus datapath.

Verification
REQ-041 Reset, then frame_tick with btn_right, model detector returns coll_right=0, coll_down=1 -> x=2, y=1, one update_done pulse.
REQ-042 x=0 with btn_left and all coll_*=0 -> x stays 0 and y falls to 0.
REQ-043 Grounded at y=1, btn_jump, coll_up=0 for four ticks -> y sequence 2,3,4, then 3 (gravity).
REQ-044 Jump with coll_up=1 on the second update -> y 2,2,1; jump_left cleared.
REQ-045 frame_tick while in WAIT_DONE -> overrun pulses once, position changes once only.
REQ-046 resetn=0 asserted during WAIT_DONE -> x=START_X, y=START_Y, IDLE, no update_done.

Source files
------------

// File: rtl/player_motion_controller_pkg.sv
// Shared definitions for the player motion controller, the collision detector
// and the tile renderer: map size, coordinate widths and FSM state encoding.
package player_motion_controller_pkg;

  localparam int unsigned TILEMAP_LENGTH = 2000;
  localparam int unsigned X_W            = 11;
  localparam int unsigned Y_W            = 4;
  localparam int unsigned JUMP_W         = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StWaitBusy,
    StWaitDone,
    StMoveX,
    StMoveY,
    StCommit
  } motion_state_e;

endpackage

// File: rtl/player_motion_controller_if.sv
// Handshake and position bus between the motion controller and the
// collision detector. The controller is the master: it owns the position and
// the start pulse, the detector answers with done and the blocked flags.
interface player_motion_controller_if;
  import player_motion_controller_pkg::*;

  logic             dbc_enable;
  logic             dbc_done;
  logic             coll_left;
  logic             coll_right;
  logic             coll_up;
  logic             coll_down;
  logic [X_W-1:0]   x_location;
  logic [Y_W-1:0]   y_location;

  modport master (
    output dbc_enable,
    output x_location,
    output y_location,
    input  dbc_done,
    input  coll_left,
    input  coll_right,
    input  coll_up,
    input  coll_down
  );

  modport slave (
    input  dbc_enable,
    input  x_location,
    input  y_location,
    output dbc_done,
    output coll_left,
    output coll_right,
    output coll_up,
    output coll_down
  );

endinterface

// File: rtl/player_motion_controller_jump_counter.sv
// Remaining-ascent counter for a jump. Clear wins over everything; a load
// combined with a decrement lands on JUMP_HEIGHT-1 so the first ascent step
// can happen in the same update that starts the jump.
module player_motion_controller_jump_counter
  import player_motion_controller_pkg::*;
#(
  parameter int unsigned JUMP_HEIGHT = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              dec,
  input  logic              clear,
  output logic [JUMP_W-1:0] jump_left
);

  localparam logic [JUMP_W-1:0] LoadVal = JUMP_W'(JUMP_HEIGHT);

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      jump_left <= '0;
    end else if (clear) begin
      jump_left <= '0;
    end else if (load) begin
      jump_left <= dec ? LoadVal - JUMP_W'(1) : LoadVal;
    end else if (dec) begin
      jump_left <= jump_left - JUMP_W'(1);
    end
  end

endmodule

// File: rtl/player_motion_controller.sv
// Per-frame player motion: latch controls on frame_tick, run one collision
// detector pass, then apply the horizontal move followed by the vertical
// (jump / gravity) move using the flags from that single pass.
module player_motion_controller #(
  parameter int unsigned TILEMAP_LENGTH = player_motion_controller_pkg::TILEMAP_LENGTH,
  parameter int unsigned START_X        = 1,
  parameter int unsigned START_Y        = 1,
  parameter int unsigned JUMP_HEIGHT    = 3
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              frame_tick,
  input  logic                              btn_left,
  input  logic                              btn_right,
  input  logic                              btn_jump,
  player_motion_controller_if.master        dbc,
  output logic                              update_done,
  output logic                              overrun
);
  import player_motion_controller_pkg::*;

  localparam logic [X_W-1:0]    XMax     = X_W'(TILEMAP_LENGTH - 1);
  localparam logic [JUMP_W-1:0] JumpLoad = JUMP_W'(JUMP_HEIGHT);

  motion_state_e     state;
  logic              left_lat;
  logic              right_lat;
  logic              jump_lat;
  logic              coll_left_lat;
  logic              coll_right_lat;
  logic              coll_up_lat;
  logic              coll_down_lat;
  logic [X_W-1:0]    x_pos;
  logic [Y_W-1:0]    y_pos;
  logic              dbc_enable_r;

  logic [JUMP_W-1:0] jump_left;
  logic [JUMP_W-1:0] jump_eff;
  logic              grounded;
  logic              start_jump;
  logic              rising;
  logic              can_rise;
  logic              move_left;
  logic              move_right;
  logic              jl_load;
  logic              jl_dec;
  logic              jl_clear;

  assign dbc.dbc_enable = dbc_enable_r;
  assign dbc.x_location = x_pos;
  assign dbc.y_location = y_pos;

  // Same-cycle drop indication, so this one is decoded rather than registered.
  assign overrun = resetn && frame_tick && (state != StIdle);

  // Move decisions from the latched buttons and the latched detector flags.
  always_comb begin
    move_left  = left_lat && !right_lat && !coll_left_lat && (x_pos != '0);
    move_right = right_lat && !left_lat && !coll_right_lat && (x_pos < XMax);
    grounded   = coll_down_lat || (y_pos == '0);
    start_jump = grounded && jump_lat && (jump_left == '0);
    // A jump starting this update ascends immediately.
    jump_eff   = start_jump ? JumpLoad : jump_left;
    rising     = (jump_eff != '0);
    can_rise   = rising && !coll_up_lat && (y_pos != '1);
    jl_load    = (state == StMoveY) && start_jump;
    jl_dec     = (state == StMoveY) && can_rise;
    jl_clear   = (state == StMoveY) && rising && !can_rise;
  end

  player_motion_controller_jump_counter #(
    .JUMP_HEIGHT (JUMP_HEIGHT)
  ) u_jump_counter (
    .clock     (clock),
    .resetn    (resetn),
    .load      (jl_load),
    .dec       (jl_dec),
    .clear     (jl_clear),
    .jump_left (jump_left)
  );

  // Sequencing FSM with registered position and pulse outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= StIdle;
      x_pos          <= X_W'(START_X);
      y_pos          <= Y_W'(START_Y);
      left_lat       <= 1'b0;
      right_lat      <= 1'b0;
      jump_lat       <= 1'b0;
      coll_left_lat  <= 1'b0;
      coll_right_lat <= 1'b0;
      coll_up_lat    <= 1'b0;
      coll_down_lat  <= 1'b0;
      dbc_enable_r   <= 1'b0;
      update_done    <= 1'b0;
    end else begin
      dbc_enable_r <= 1'b0;
      update_done  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (frame_tick) begin
            left_lat     <= btn_left;
            right_lat    <= btn_right;
            jump_lat     <= btn_jump;
            dbc_enable_r <= 1'b1;
            state        <= StRequest;
          end
        end
        StRequest: begin
          state <= StWaitBusy;
        end
        // A detector run left over from before reset still shows done=0
        // here, so waiting for busy then done keeps the handshake aligned.
        StWaitBusy: begin
          if (!dbc.dbc_done) state <= StWaitDone;
        end
        StWaitDone: begin
          if (dbc.dbc_done) begin
            coll_left_lat  <= dbc.coll_left;
            coll_right_lat <= dbc.coll_right;
            coll_up_lat    <= dbc.coll_up;
            coll_down_lat  <= dbc.coll_down;
            state          <= StMoveX;
          end
        end
        StMoveX: begin
          if (move_left) begin
            x_pos <= x_pos - X_W'(1);
          end else if (move_right) begin
            x_pos <= x_pos + X_W'(1);
          end
          state <= StMoveY;
        end
        StMoveY: begin
          if (can_rise) begin
            y_pos <= y_pos + Y_W'(1);
          end else if (!rising && !grounded) begin
            y_pos <= y_pos - Y_W'(1);
          end
          update_done <= 1'b1;
          state       <= StCommit;
        end
        StCommit: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: directed scenarios followed by random
// updates, each checked against a rule-level position model.
module tb_player_motion_controller;

  localparam int unsigned TL = 8;
  localparam int unsigned SX = 1;
  localparam int unsigned SY = 1;
  localparam int unsigned JH = 3;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_jump = 1'b0;
  logic update_done;
  logic overrun;

  player_motion_controller_if dbc_if ();

  player_motion_controller #(
    .TILEMAP_LENGTH (TL),
    .START_X        (SX),
    .START_Y        (SY),
    .JUMP_HEIGHT    (JH)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .dbc         (dbc_if.master),
    .update_done (update_done),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass = 0;
  int mx;
  int my;
  int mjl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_reset();
    mx = SX;
    my = SY;
    mjl = 0;
  endfunction

  function automatic void model_update(bit l, bit r, bit j, bit cl, bit cr, bit cu, bit cd);
    bit grounded;
    if (l && !r && !cl && mx > 0) mx = mx - 1;
    else if (r && !l && !cr && mx < int'(TL) - 1) mx = mx + 1;
    grounded = cd || (my == 0);
    if (grounded && j && mjl == 0) mjl = JH;
    if (mjl > 0) begin
      if (!cu && my < 15) begin
        my = my + 1;
        mjl = mjl - 1;
      end else begin
        mjl = 0;
      end
    end else if (!grounded) begin
      my = my - 1;
    end
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    model_reset();
    check("reset_x", dbc_if.x_location, SX);
    check("reset_y", dbc_if.y_location, SY);
    check("reset_update_done", update_done, 0);
    check("reset_dbc_enable", dbc_if.dbc_enable, 0);
    check("reset_overrun", overrun, 0);
  endtask

  task automatic scramble_coll();
    dbc_if.coll_left  = 1'($urandom);
    dbc_if.coll_right = 1'($urandom);
    dbc_if.coll_up    = 1'($urandom);
    dbc_if.coll_down  = 1'($urandom);
  endtask

  // One full frame update against a detector model that stays busy for `busy` cycles.
  task automatic run_update(input bit l, input bit r, input bit j, input bit cl, input bit cr,
                            input bit cu, input bit cd, input int busy, input bit inject);
    int lat;
    btn_left = l;
    btn_right = r;
    btn_jump = j;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    btn_left = 1'($urandom);
    btn_right = 1'($urandom);
    btn_jump = 1'($urandom);
    check("dbc_enable_pulse", dbc_if.dbc_enable, 1);
    dbc_if.dbc_done = 1'b0;
    scramble_coll();
    for (int i = 0; i < busy; i++) begin
      step();
      if (i == 0) check("dbc_enable_single", dbc_if.dbc_enable, 0);
      check("x_stable_busy", dbc_if.x_location, mx);
      check("y_stable_busy", dbc_if.y_location, my);
      if (inject && i == 4) begin
        frame_tick = 1'b1;
        #1;
        check("overrun_pulse", overrun, 1);
      end else if (inject && i == 5) begin
        frame_tick = 1'b0;
        #1;
        check("overrun_clear", overrun, 0);
      end
    end
    dbc_if.coll_left = cl;
    dbc_if.coll_right = cr;
    dbc_if.coll_up = cu;
    dbc_if.coll_down = cd;
    dbc_if.dbc_done = 1'b1;
    step();
    scramble_coll();
    model_update(l, r, j, cl, cr, cu, cd);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (update_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("update_done_latency", lat, 2);
    check("x_after_update", dbc_if.x_location, mx);
    check("y_after_update", dbc_if.y_location, my);
    step();
    check("update_done_single", update_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int pulses;
    bit l, r, j, cl, cr, cu, cd;
    dbc_if.dbc_done = 1'b1;
    dbc_if.coll_left = 1'b0;
    dbc_if.coll_right = 1'b0;
    dbc_if.coll_up = 1'b0;
    dbc_if.coll_down = 1'b0;

    do_reset();

    // Walk right on the ground.
    run_update(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    check("walk_right_x", dbc_if.x_location, 2);
    check("walk_right_y", dbc_if.y_location, 1);

    // Left edge saturation while falling.
    do_reset();
    run_update(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    run_update(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    check("left_edge_x", dbc_if.x_location, 0);
    check("left_edge_y", dbc_if.y_location, 0);

    // Full jump then gravity.
    do_reset();
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    check("jump_y1", dbc_if.y_location, 2);
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    check("jump_y2", dbc_if.y_location, 3);
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    check("jump_y3", dbc_if.y_location, 4);
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    check("jump_y4", dbc_if.y_location, 3);

    // Head bump on the second update.
    do_reset();
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    check("bump_y1", dbc_if.y_location, 2);
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9, 1'b0);
    check("bump_y2", dbc_if.y_location, 2);
    run_update(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    check("bump_y3", dbc_if.y_location, 1);

    // Dropped tick while waiting on the detector.
    do_reset();
    run_update(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    check("overrun_single_move_x", dbc_if.x_location, 2);

    // Right edge saturation.
    for (int i = 0; i < 7; i++) begin
      run_update(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    end
    check("right_edge_x", dbc_if.x_location, TL - 1);

    // Reset during the detector wait abandons the update.
    btn_right = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    dbc_if.dbc_done = 1'b0;
    for (int i = 0; i < 4; i++) step();
    resetn = 1'b0;
    step();
    model_reset();
    check("abort_x", dbc_if.x_location, SX);
    check("abort_y", dbc_if.y_location, SY);
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (update_done === 1'b1) pulses++;
    end
    dbc_if.dbc_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (update_done === 1'b1) pulses++;
    end
    check("abort_no_update_done", pulses, 0);
    check("abort_x_held", dbc_if.x_location, SX);
    run_update(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0);

    // Random updates.
    for (int n = 0; n < 40; n++) begin
      l = 1'($urandom);
      r = 1'($urandom);
      j = 1'($urandom);
      cl = ($urandom_range(0, 3) == 0);
      cr = ($urandom_range(0, 3) == 0);
      cu = ($urandom_range(0, 3) == 0);
      cd = 1'($urandom);
      busy = $urandom_range(9, 12);
      run_update(l, r, j, cl, cr, cu, cd, busy, ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
